// File: rtl/neuron_cfg_loader_pkg.sv
// Shared definitions for the neuron configuration loader: command codes,
// header field layout and FSM state encoding.
package nn_cfg_pkg;

    typedef enum logic [1:0] {
        CMD_WEIGHT = 2'b00,
        CMD_BIAS   = 2'b01
    } cmd_t;

    // Header layout: [31:30] cmd, [29:22] layer, [21:12] neuron, [11:0] count
    localparam int HDR_CMD_LSB    = 30;
    localparam int HDR_CMD_W      = 2;
    localparam int HDR_LAYER_LSB  = 22;
    localparam int HDR_LAYER_W    = 8;
    localparam int HDR_NEURON_LSB = 12;
    localparam int HDR_NEURON_W   = 10;
    localparam int HDR_COUNT_LSB  = 0;
    localparam int HDR_COUNT_W    = 12;

    typedef logic [1:0] state_t;
    localparam state_t ST_HDR = 2'd0;
    localparam state_t ST_WGT = 2'd1;
    localparam state_t ST_BIA = 2'd2;

endpackage

// File: rtl/neuron_cfg_loader.sv
// Turns the host command/payload word stream into the broadcast weight/bias
// write protocol of the neuron array. Always ready outside reset.
module neuron_cfg_loader
    import nn_cfg_pkg::*;
#(
    parameter int dataWidth  = 16,
    parameter int maxWeights = 784
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [dataWidth-1:0] mWeight,
    output logic                 mWeightValid,
    output logic [31:0]          mBias,
    output logic                 mBiasValid,
    output logic [31:0]          config_layer_num,
    output logic [31:0]          config_neuron_num,
    output logic                 busy,
    output logic                 load_done,
    output logic                 cmd_err
);

    localparam logic [HDR_COUNT_W-1:0] MAX_CNT = HDR_COUNT_W'(maxWeights);

    // Handshake: a word moves on any edge where s_valid and s_ready are both high.
    state_t                 state_q, state_d;
    logic [HDR_COUNT_W-1:0] remaining_q, remaining_d;
    logic                   ready_q;
    logic [dataWidth-1:0]   mweight_q, mweight_d;
    logic                   wvalid_q, wvalid_d;
    logic [31:0]            mbias_q, mbias_d;
    logic                   bvalid_q, bvalid_d;
    logic [31:0]            layer_q, layer_d;
    logic [31:0]            neuron_q, neuron_d;
    logic                   busy_q;
    logic                   last_q, last_d;
    logic                   done_q;
    logic                   err_q, err_d;

    logic                   accept;
    logic [HDR_CMD_W-1:0]   hdr_cmd;
    logic [HDR_COUNT_W-1:0] hdr_count;
    logic                   hdr_illegal;

    assign accept    = s_valid & ready_q;
    assign hdr_cmd   = s_data[HDR_CMD_LSB +: HDR_CMD_W];
    assign hdr_count = s_data[HDR_COUNT_LSB +: HDR_COUNT_W];
    assign hdr_illegal = hdr_cmd[1] ||
        ((hdr_cmd == CMD_WEIGHT) && ((hdr_count == '0) || (hdr_count > MAX_CNT)));

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        mweight_d   = mweight_q;
        wvalid_d    = 1'b0;
        mbias_d     = mbias_q;
        bvalid_d    = 1'b0;
        layer_d     = layer_q;
        neuron_d    = neuron_q;
        last_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (accept) begin
                    if (hdr_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        layer_d     = 32'(s_data[HDR_LAYER_LSB +: HDR_LAYER_W]);
                        neuron_d    = 32'(s_data[HDR_NEURON_LSB +: HDR_NEURON_W]);
                        remaining_d = hdr_count;
                        state_d     = (hdr_cmd == CMD_WEIGHT) ? ST_WGT : ST_BIA;
                    end
                end
            end
            ST_WGT: begin
                if (accept) begin
                    mweight_d   = s_data[dataWidth-1:0];
                    wvalid_d    = 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == HDR_COUNT_W'(1)) begin
                        state_d = ST_HDR;
                        last_d  = 1'b1;
                    end
                end
            end
            ST_BIA: begin
                if (accept) begin
                    mbias_d  = s_data;
                    bvalid_d = 1'b1;
                    last_d   = 1'b1;
                    state_d  = ST_HDR;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HDR;
            remaining_q <= '0;
            ready_q     <= 1'b0;
            mweight_q   <= '0;
            wvalid_q    <= 1'b0;
            mbias_q     <= '0;
            bvalid_q    <= 1'b0;
            layer_q     <= '0;
            neuron_q    <= '0;
            busy_q      <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            ready_q     <= 1'b1;
            mweight_q   <= mweight_d;
            wvalid_q    <= wvalid_d;
            mbias_q     <= mbias_d;
            bvalid_q    <= bvalid_d;
            layer_q     <= layer_d;
            neuron_q    <= neuron_d;
            busy_q      <= (state_d != ST_HDR);
            last_q      <= last_d;
            // Done trails the final strobe by one cycle.
            done_q      <= last_q;
            err_q       <= err_d;
        end
    end

    assign s_ready           = ready_q;
    assign mWeight           = mweight_q;
    assign mWeightValid      = wvalid_q;
    assign mBias             = mbias_q;
    assign mBiasValid        = bvalid_q;
    assign config_layer_num  = layer_q;
    assign config_neuron_num = neuron_q;
    assign busy              = busy_q;
    assign load_done         = done_q;
    assign cmd_err           = err_q;

endmodule

// File: tb/tb_neuron_cfg_loader.sv
// Directed and randomized checks of neuron_cfg_loader against a word-level
// model of the command stream.
module tb_neuron_cfg_loader;

    localparam int DW   = 16;
    localparam int MAXW = 784;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] mWeight;
    logic          mWeightValid;
    logic [31:0]   mBias;
    logic          mBiasValid;
    logic [31:0]   config_layer_num;
    logic [31:0]   config_neuron_num;
    logic          busy;
    logic          load_done;
    logic          cmd_err;

    int total = 0;
    int bad   = 0;

    // Model: words_left counts payload words still owed by the open command
    int          m_left;
    bit          m_bias;
    bit          m_last;
    bit          m_ready;
    logic [31:0] m_layer, m_neuron, m_b;
    logic [DW-1:0] m_w;

    int wstrobes, bstrobes, errs;

    neuron_cfg_loader #(.dataWidth(DW), .maxWeights(MAXW)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mWeight(mWeight), .mWeightValid(mWeightValid), .mBias(mBias),
        .mBiasValid(mBiasValid), .config_layer_num(config_layer_num),
        .config_neuron_num(config_neuron_num), .busy(busy),
        .load_done(load_done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_bias = 0; m_last = 0; m_ready = 0;
        m_layer = 0; m_neuron = 0; m_b = 0; m_w = '0;
    endtask

    task automatic step(input bit v, input logic [31:0] d);
        bit acc, e_wv, e_bv, e_err, e_done;
        int cnt;
        s_valid = v;
        s_data  = d;
        @(posedge clk);
        acc = v && m_ready;
        e_wv = 0; e_bv = 0; e_err = 0;
        e_done = m_last;
        m_last = 0;
        if (acc) begin
            if (m_left == 0) begin
                cnt = int'(d[11:0]);
                if (d[31] || (d[31:30] == 2'b00 && (cnt == 0 || cnt > MAXW))) begin
                    e_err = 1;
                end else begin
                    m_layer  = {24'd0, d[29:22]};
                    m_neuron = {22'd0, d[21:12]};
                    m_bias   = (d[31:30] == 2'b01);
                    m_left   = m_bias ? 1 : cnt;
                end
            end else begin
                if (m_bias) begin
                    e_bv = 1; m_b = d;
                end else begin
                    e_wv = 1; m_w = d[DW-1:0];
                end
                m_left--;
                if (m_left == 0) m_last = 1;
            end
        end
        m_ready = 1;
        #1;
        if (mWeightValid === 1'b1) wstrobes++;
        if (mBiasValid === 1'b1) bstrobes++;
        if (cmd_err === 1'b1) errs++;
        chk("s_ready", 32'(s_ready), 32'd1);
        chk("wvalid", 32'(mWeightValid), 32'(e_wv));
        chk("bvalid", 32'(mBiasValid), 32'(e_bv));
        chk("mweight", 32'(mWeight), 32'(m_w));
        chk("mbias", mBias, m_b);
        chk("layer", config_layer_num, m_layer);
        chk("neuron", config_neuron_num, m_neuron);
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("cmd_err", 32'(cmd_err), 32'(e_err));
        chk("load_done", 32'(load_done), 32'(e_done));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_wv"}, 32'(mWeightValid), 32'd0);
        chk({tag, "_bv"}, 32'(mBiasValid), 32'd0);
        chk({tag, "_mw"}, 32'(mWeight), 32'd0);
        chk({tag, "_mb"}, mBias, 32'd0);
        chk({tag, "_layer"}, config_layer_num, 32'd0);
        chk({tag, "_neuron"}, config_neuron_num, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(load_done), 32'd0);
        chk({tag, "_err"}, 32'(cmd_err), 32'd0);
    endtask

    function automatic logic [31:0] hdr(input int cmd, input int layer, input int neuron, input int count);
        return {cmd[1:0], layer[7:0], neuron[9:0], count[11:0]};
    endfunction

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0;
        model_reset();
        wstrobes = 0; bstrobes = 0; errs = 0;
        repeat (2) @(posedge clk);
        #1 chk_cleared("reset");
        rst = 1'b0;
        step(0, 0);

        // Weight L1 N3, three words
        step(1, 32'h0040_3003);
        chk("t1_layer", config_layer_num, 32'd1);
        chk("t1_neuron", config_neuron_num, 32'd3);
        wstrobes = 0;
        step(1, 32'h11);
        chk("t1_w0", 32'(mWeight), 32'h11);
        step(1, 32'h22);
        step(1, 32'h33);
        chk("t1_w2", 32'(mWeight), 32'h33);
        step(0, 0);
        chk("t1_done", 32'(load_done), 32'd1);
        chk("t1_count", wstrobes, 32'd3);

        // Bias L2 N5
        step(1, 32'h4080_5000);
        step(1, 32'h0000_ABCD);
        chk("t2_bias", mBias, 32'h0000_ABCD);
        chk("t2_layer", config_layer_num, 32'd2);
        chk("t2_neuron", config_neuron_num, 32'd5);
        step(0, 0);

        // Maximum count with a 2-cycle gap at word 400
        step(1, hdr(0, 3, 7, MAXW));
        wstrobes = 0;
        for (int i = 0; i < MAXW; i++) begin
            if (i == 400) begin
                step(0, 0);
                step(0, 0);
            end
            step(1, $urandom);
        end
        step(0, 0);
        chk("t3_count", wstrobes, 32'(MAXW));

        // Illegal headers, then a legal one
        errs = 0; wstrobes = 0; bstrobes = 0;
        step(1, hdr(2, 9, 9, 5));
        step(1, hdr(0, 9, 9, 0));
        step(1, hdr(0, 9, 9, MAXW + 1));
        step(0, 0);
        chk("t4_errs", errs, 32'd3);
        chk("t4_strobes", wstrobes + bstrobes, 32'd0);
        chk("t4_layer", config_layer_num, 32'd3);
        step(1, hdr(1, 6, 11, 0));
        step(1, 32'hDEAD_BEEF);
        step(0, 0);

        // Reset mid-command
        step(1, hdr(0, 4, 9, 10));
        for (int i = 0; i < 5; i++) step(1, $urandom);
        #2 rst = 1'b1;
        #1 chk_cleared("rst_mid");
        @(posedge clk);
        #1 chk("rst_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        s_valid = 1'b0;
        model_reset();
        step(0, 0);
        step(1, hdr(0, 4, 9, 10));
        wstrobes = 0;
        for (int i = 0; i < 10; i++) step(1, $urandom);
        step(0, 0);
        chk("t5_count", wstrobes, 32'd10);

        // Weight L0 N0 then bias L0 N1 back-to-back
        step(1, hdr(0, 0, 0, 2));
        step(1, 32'h1234);
        step(1, 32'h5678);
        chk("t6_neuron_w", config_neuron_num, 32'd0);
        step(1, hdr(1, 0, 1, 0));
        chk("t6_neuron_b", config_neuron_num, 32'd1);
        step(1, 32'h0BAD_F00D);
        step(0, 0);

        // Random command stream
        for (int n = 0; n < 600; n++) begin
            bit v;
            logic [31:0] d;
            int r;
            v = ($urandom_range(0, 4) != 0);
            if (m_left == 0) begin
                r = $urandom_range(0, 9);
                if (r < 6)       d = hdr(0, $urandom_range(0, 255), $urandom_range(0, 1023), $urandom_range(1, 12));
                else if (r < 8)  d = hdr(1, $urandom_range(0, 255), $urandom_range(0, 1023), $urandom_range(0, 4095));
                else if (r == 8) d = hdr(0, 1, 1, ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(MAXW + 1, 4095));
                else             d = hdr($urandom_range(2, 3), 1, 1, $urandom_range(0, 4095));
            end else begin
                d = $urandom;
            end
            step(v, d);
        end
        repeat (3) step(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
